rotary_paddle_ctrl: RTL
=======================

// Module: rotary_paddle_ctrl
// PURPOSE
//  Input-conditioning stage directly upstream of the game logic in the breakout design.
//  Turns the raw active-low rotary-encoder pins (A/B) and push-button into clean game controls:
//   - a 10-bit paddle X position, frame-synchronous;
//   - a one-cycle launch pulse.
//  Runs in the 25 MHz pixel-clock domain.
//  Uses vsync from the sync generator so paddle_x changes only at frame start (no tearing).
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable clocks required before a filtered input changes (10 ms @25 MHz)
//  STEP             8       pixels moved per detent
//  PADDLE_W         64      paddle width in pixels
//  X_MIN            0       leftmost legal paddle_x
//  X_MAX            640     right playfield edge; paddle_x max = X_MAX-PADDLE_W
//  X_RESET          288     paddle_x after reset (centred)
//  ACCEL_WINDOW     1250000 clocks; fast-spin window (used only with ROT_ACCEL_EN)
// PORTS
//  clk25      in   1   pixel clock, all logic on posedge
//  rst_n      in   1   async active-low reset
//  rota_n     in   1   encoder A, raw pin, active-low, asynchronous
//  rotb_n     in   1   encoder B, raw pin, active-low, asynchronous
//  de_n       in   1   push-button, raw pin, active-low, asynchronous
//  vsync      in   1   vertical sync from sync generator (active-low pulse)
//  paddle_x   out  10  paddle left-edge X, updated once per frame
//  launch     out  1   one-clk25 pulse per debounced button press
//  dir_dbg    out  2   last detent direction: 01=CW(+), 10=CCW(-), 00=none since reset
// BEHAVIOUR
//  Reset (async assert, sync release): all registers clear.
//   - paddle_x=X_RESET, pos=X_RESET, launch=0, dir_dbg=00.
//   - Sync FFs and filtered A/B/btn = 0 (released, after inversion).
//   - Debounce counters = 0.
//   - Reset asserted mid-operation aborts any pending step or press immediately.
//  Input path: invert each pin (active-high internally).
//   - 2-FF synchroniser per input.
//   - Debounce counter per input:
//     - sync value == filtered: counter cleared;
//     - sync value != filtered: counter increments;
//     - counter reaches DEBOUNCE_CYCLES-1: filtered takes sync value, counter clears.
//   - Glitch shorter than DEBOUNCE_CYCLES never reaches filtered.
//   - Pin-to-filtered latency = 2+DEBOUNCE_CYCLES clks.
//  Quadrature decode: detent event on rising edge of filtered A (prev 0, now 1).
//   - filtered B=0: CW, +step. filtered B=1: CCW, -step.
//   - Edges on B alone: no event.
//  Position arithmetic: 11-bit signed intermediate, result saturated to [X_MIN, X_MAX-PADDLE_W].
//   - Never wraps.
//   - A step toward a wall already reached leaves pos unchanged; dir_dbg still updates.
//  Frame latch: vsync falling edge (registered prev vs current) loads paddle_x <= pos.
//   - Detent and vsync edge in the same cycle: paddle_x takes pre-update pos.
//   - The new pos appears next frame.
//   - Multiple detents within one frame accumulate in pos.
//   - vsync stuck: paddle_x holds.
//  Launch: filtered button rising edge -> launch=1 for exactly one clk.
//   - Held button gives no repeats; release gives no pulse.
//   - Latency from pin edge: 3+DEBOUNCE_CYCLES clks.
// CONFIGURATION
//  ROT_ACCEL_EN defined: step = STEP*4 when the detent has the same direction as the previous one
//   and arrives < ACCEL_WINDOW clks after it; otherwise STEP.
//   - Window counter saturates at ACCEL_WINDOW.
//   - Counter restarts at 0 on every detent and on reset.
//  ROT_ACCEL_EN undefined: step always STEP; no window counter synthesised.
// STRUCTURE
//  Shared package/header (rotary_pkg):
//   - DIR_NONE/DIR_CW/DIR_CCW 2-bit codes;
//   - DEBOUNCE_CYCLES default;
//   - playfield constants X_MIN/X_MAX/PADDLE_W shared with game.
//  Sub-module: input_debouncer (sync2 + counter + filtered reg + rise-edge strobe), instantiated 3x.
//  Top of block: quadrature decoder, saturating position register, frame latch, optional accel counter.
// TESTING (bench uses DEBOUNCE_CYCLES=4, STEP=8, PADDLE_W=64, X_MAX=640, X_RESET=288)
//  1. Reset: rst_n low mid-run -> paddle_x=288, launch=0, dir_dbg=00 immediately, without a clock.
//  2. Glitch: rota_n low for 3 clks -> no detent, pos stays 288.
//     rota_n low for 10 clks with rotb_n high -> pos 296.
//     paddle_x=296 only after next vsync fall.
//  3. CCW detent (A rises while B=1) -> dir_dbg=10, pos 288->280.
//     3 detents in one frame -> paddle_x 288->264 at one vsync edge.
//  4. Saturation:
//     - 80 CW detents -> paddle_x=576, stays 576 on a further CW.
//     - 80 CCW detents -> 0, never wraps to 1016.
//  5. Button held 1000 clks -> exactly one launch pulse at pin-fall+7 clks; release -> none.
//     Detent coinciding with vsync fall -> old value latched.
//  6. ROT_ACCEL_EN, ACCEL_WINDOW=100:
//     - two CW detents 50 clks apart -> +8 then +32;
//     - 150 clks apart -> +8, +8;
//     - CW then CCW 50 apart -> +8, -8.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared codes and playfield constants for the rotary paddle input stage and the game logic.
package rotary_pkg;

   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_CW   = 2'b01,
      DIR_CCW  = 2'b10
   } dir_e;

   localparam int DEBOUNCE_CYCLES_DEF = 250000;
   localparam int X_MIN_DEF           = 0;
   localparam int X_MAX_DEF           = 640;
   localparam int PADDLE_W_DEF        = 64;

   // Clamp a signed intermediate position into [lo, hi]; the result never wraps.
   function automatic logic [9:0] sat_pos(input logic signed [10:0] v, input int lo, input int hi);
      if (int'(v) < lo) return 10'(lo);
      if (int'(v) > hi) return 10'(hi);
      return v[9:0];
   endfunction

endpackage

// File: rtl/input_debouncer.sv
// Raw active-low pin -> inverted, 2-FF synchronised, counter-debounced level plus a rise strobe.
module input_debouncer #(
   parameter int CYCLES = 4
) (
   input  logic clk25,
   input  logic rst_n,
   input  logic pin_n,
   output logic filt,
   output logic rise
);
   localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [1:0]       sync_q, sync_d;
   logic             filt_q, filt_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every signal gets a default before any branch, so no path leaves it unassigned (no latch).
   always_comb begin
      sync_d = {sync_q[0], ~pin_n};
      filt_d = filt_q;
      rise_d = 1'b0;
      cnt_d  = cnt_q;
      if (sync_q[1] == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(CYCLES - 1)) begin
         filt_d = sync_q[1];
         rise_d = sync_q[1];
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         filt_q <= 1'b0;
         rise_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
         rise_q <= rise_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filt = filt_q;
   assign rise = rise_q;

endmodule

// File: rtl/rotary_paddle_ctrl.sv
// Rotary encoder + button conditioning: saturating paddle position latched on vsync fall, launch pulse.
// Optional ROT_ACCEL_EN: same-direction detents inside ACCEL_WINDOW clocks move STEP*4.
module rotary_paddle_ctrl
   import rotary_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int STEP            = 8,
   parameter int PADDLE_W        = PADDLE_W_DEF,
   parameter int X_MIN           = X_MIN_DEF,
   parameter int X_MAX           = X_MAX_DEF,
   parameter int X_RESET         = 288,
   parameter int ACCEL_WINDOW    = 1250000
) (
   input  logic       clk25,
   input  logic       rst_n,
   input  logic       rota_n,
   input  logic       rotb_n,
   input  logic       de_n,
   input  logic       vsync,
   output logic [9:0] paddle_x,
   output logic       launch,
   output logic [1:0] dir_dbg
);
   localparam int                X_HI   = X_MAX - PADDLE_W;
   localparam logic signed [10:0] STEP_S = 11'(STEP);

   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_int_n;

   // Assert follows rst_n asynchronously; release is aligned to clk25.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= rst_sync_d;
   end
   assign rst_int_n = rst_sync_q[1];

   logic a_rise, b_filt, btn_rise;
   logic unused_a_filt, unused_b_rise, unused_btn_filt;

   input_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk25(clk25), .rst_n(rst_int_n), .pin_n(rota_n), .filt(unused_a_filt), .rise(a_rise));
   input_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk25(clk25), .rst_n(rst_int_n), .pin_n(rotb_n), .filt(b_filt), .rise(unused_b_rise));
   input_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_btn (
      .clk25(clk25), .rst_n(rst_int_n), .pin_n(de_n), .filt(unused_btn_filt), .rise(btn_rise));

   dir_e              dir_q, dir_d, dir_new;
   logic [9:0]        pos_q, pos_d;
   logic [9:0]        paddle_q, paddle_d;
   logic              launch_q, launch_d;
   logic              vs_prev_q, vs_prev_d;
   logic signed [10:0] step_s, sum_s;

   assign dir_new = b_filt ? DIR_CCW : DIR_CW;

`ifdef ROT_ACCEL_EN
   localparam int                WIN_W       = $clog2(ACCEL_WINDOW + 1);
   localparam logic signed [10:0] STEP_FAST_S = 11'(STEP * 4);

   logic [WIN_W-1:0] win_q, win_d;

   always_comb begin
      win_d = win_q;
      if (a_rise)                              win_d = '0;
      else if (win_q != WIN_W'(ACCEL_WINDOW))  win_d = win_q + 1'b1;
      step_s = ((dir_new == dir_q) && (win_q < WIN_W'(ACCEL_WINDOW))) ? STEP_FAST_S : STEP_S;
   end

   always_ff @(posedge clk25 or negedge rst_int_n) begin
      if (!rst_int_n) win_q <= '0;
      else            win_q <= win_d;
   end
`else
   assign step_s = STEP_S;
`endif

   always_comb begin
      pos_d     = pos_q;
      dir_d     = dir_q;
      paddle_d  = paddle_q;
      launch_d  = btn_rise;
      vs_prev_d = vsync;
      sum_s     = '0;
      if (a_rise) begin
         sum_s = (dir_new == DIR_CW) ? $signed({1'b0, pos_q}) + step_s
                                     : $signed({1'b0, pos_q}) - step_s;
         pos_d = sat_pos(sum_s, X_MIN, X_HI);
         dir_d = dir_new;
      end
      // Latch the pre-update pos, so a detent on the vsync edge shows up next frame.
      if (vs_prev_q && !vsync) paddle_d = pos_q;
   end

   always_ff @(posedge clk25 or negedge rst_int_n) begin
      if (!rst_int_n) begin
         pos_q     <= 10'(X_RESET);
         paddle_q  <= 10'(X_RESET);
         dir_q     <= DIR_NONE;
         launch_q  <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         pos_q     <= pos_d;
         paddle_q  <= paddle_d;
         dir_q     <= dir_d;
         launch_q  <= launch_d;
         vs_prev_q <= vs_prev_d;
      end
   end

   assign paddle_x = paddle_q;
   assign launch   = launch_q;
   assign dir_dbg  = dir_q;

endmodule
